// File: rtl/stopwatch_pkg.sv
// Shared widths, field indices and the packed epoch type for the stopwatch timer.
package stopwatch_pkg;

  localparam int unsigned FIELD_W    = 7;
  localparam int unsigned NUM_FIELDS = 4;
  localparam int unsigned EPOCH_W    = 28;

  localparam int unsigned CS  = 0;
  localparam int unsigned SEC = 1;
  localparam int unsigned MIN = 2;
  localparam int unsigned HR  = 3;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

  // Index 0 is the centisecond field in bits [6:0]; index 3 is hours in [27:21].
  typedef logic [NUM_FIELDS-1:0][FIELD_W-1:0] epoch_t;

endpackage

// File: rtl/tick_divider.sv
// Divides the system clock into a single-cycle count enable at TICK_HZ.
module tick_divider #(
  parameter int unsigned CLOCK_HZ = 50_000_000,
  parameter int unsigned TICK_HZ  = 100
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned DIV   = CLOCK_HZ / TICK_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;

  // Phase freezes while run is low so pausing neither gains nor loses time.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear) begin
      div_cnt_d = '0;
    end else if (run) begin
      div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign tick = run && (div_cnt_q == LAST);

endmodule

// File: rtl/stopwatch_timer.sv
// Up/down h:m:s:cs stopwatch with load, expiry/overflow pulses and lap capture.
// Lap capture is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLOCK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned HOURS_MOD = 24
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               run,
  input  logic               clear,
  input  logic               mode,
  input  logic               load,
  input  logic [EPOCH_W-1:0] load_value,
  input  logic               lap,
  output logic [EPOCH_W-1:0] epoch,
  output logic [EPOCH_W-1:0] lap_epoch,
  output logic               lap_valid,
  output logic               overflow,
  output logic               done
);

  localparam epoch_t FIELD_MAX = {FIELD_W'(HOURS_MOD - 1), FIELD_W'(MIN_MAX),
                                  FIELD_W'(SEC_MAX), FIELD_W'(TICK_HZ - 1)};

  logic   tick;
  epoch_t epoch_q, epoch_d;
  epoch_t inc_c, dec_c, load_c, load_raw_c;
  logic   wrap_c, borrow_c, is_zero_c;
  logic   overflow_q, overflow_d;
  logic   done_q, done_d;

  tick_divider #(
    .CLOCK_HZ(CLOCK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_divider (
    .clock  (clock),
    .reset_n(reset_n),
    .run    (run),
    .clear  (clear),
    .tick   (tick)
  );

  assign load_raw_c = epoch_t'(load_value);
  assign is_zero_c  = (epoch_q == '0);

  // Ripple increment/decrement across fields; a carry out of hours is the wrap.
  always_comb begin
    inc_c    = epoch_q;
    dec_c    = epoch_q;
    load_c   = load_raw_c;
    wrap_c   = 1'b1;
    borrow_c = 1'b1;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (wrap_c) begin
        if (epoch_q[i] >= FIELD_MAX[i]) begin
          inc_c[i] = '0;
        end else begin
          inc_c[i] = epoch_q[i] + FIELD_W'(1);
          wrap_c   = 1'b0;
        end
      end
      if (borrow_c) begin
        if (epoch_q[i] == '0) begin
          dec_c[i] = FIELD_MAX[i];
        end else begin
          dec_c[i] = epoch_q[i] - FIELD_W'(1);
          borrow_c = 1'b0;
        end
      end
      if (load_raw_c[i] > FIELD_MAX[i]) begin
        load_c[i] = FIELD_MAX[i];
      end
    end
  end

  always_comb begin
    epoch_d    = epoch_q;
    overflow_d = 1'b0;
    done_d     = 1'b0;
    if (clear) begin
      epoch_d = '0;
    end else if (load) begin
      epoch_d = load_c;
    end else if (tick) begin
      if (!mode) begin
        epoch_d    = inc_c;
        overflow_d = wrap_c;
      end else if (!is_zero_c) begin
        epoch_d = dec_c;
        done_d  = (dec_c == '0);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      epoch_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      epoch_q    <= epoch_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign epoch    = epoch_q;
  assign overflow = overflow_q;
  assign done     = done_q;

`ifdef STOPWATCH_LAP_EN
  epoch_t lap_epoch_q, lap_epoch_d;
  logic   lap_valid_q, lap_valid_d;

  // Captures the pre-update epoch; only reset clears the valid flag.
  always_comb begin
    lap_epoch_d = lap_epoch_q;
    lap_valid_d = lap_valid_q;
    if (lap) begin
      lap_epoch_d = epoch_q;
      lap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lap_epoch_q <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_epoch_q <= lap_epoch_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_epoch = lap_epoch_q;
  assign lap_valid = lap_valid_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_epoch  = '0;
  assign lap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_timer.sv
// Self-checking bench for stopwatch_timer against a total-centisecond reference model.
module tb_stopwatch_timer;

  localparam int unsigned CLOCK_HZ  = 1000;
  localparam int unsigned TICK_HZ   = 100;
  localparam int unsigned HOURS_MOD = 24;
  localparam int unsigned DIV       = CLOCK_HZ / TICK_HZ;
  localparam int unsigned DAY       = HOURS_MOD * 3600 * TICK_HZ;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n, run, clear, mode, load, lap;
  logic [27:0] load_value;
  logic [27:0] epoch, lap_epoch;
  logic        lap_valid, overflow, done;

  int checks   = 0;
  int failures = 0;

  // Reference state: the epoch as a single count of centiseconds since 0.
  int unsigned m_total, m_phase, m_lap_total;
  bit          m_lap_valid, m_ovf, m_done;

  stopwatch_timer #(
    .CLOCK_HZ (CLOCK_HZ),
    .TICK_HZ  (TICK_HZ),
    .HOURS_MOD(HOURS_MOD)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .run       (run),
    .clear     (clear),
    .mode      (mode),
    .load      (load),
    .load_value(load_value),
    .lap       (lap),
    .epoch     (epoch),
    .lap_epoch (lap_epoch),
    .lap_valid (lap_valid),
    .overflow  (overflow),
    .done      (done)
  );

  always #5 clock = ~clock;

  function automatic logic [27:0] mk(input int unsigned h, input int unsigned m,
                                     input int unsigned s, input int unsigned cs);
    return {7'(h), 7'(m), 7'(s), 7'(cs)};
  endfunction

  function automatic logic [27:0] to_epoch(input int unsigned total);
    int unsigned t;
    int unsigned cs, s, m;
    t  = total;
    cs = t % TICK_HZ;  t = t / TICK_HZ;
    s  = t % 60;       t = t / 60;
    m  = t % 60;       t = t / 60;
    return mk(t, m, s, cs);
  endfunction

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  function automatic int unsigned clamp_total(input logic [27:0] v);
    int unsigned h, m, s, cs;
    cs = min_u(int'(v[6:0]), TICK_HZ - 1);
    s  = min_u(int'(v[13:7]), 59);
    m  = min_u(int'(v[20:14]), 59);
    h  = min_u(int'(v[27:21]), HOURS_MOD - 1);
    return ((h * 60 + m) * 60 + s) * TICK_HZ + cs;
  endfunction

  function automatic logic [27:0] exp_lap_epoch();
    return LAP_EN ? to_epoch(m_lap_total) : 28'd0;
  endfunction

  function automatic bit exp_lap_valid();
    return LAP_EN && m_lap_valid;
  endfunction

  task automatic model_reset();
    m_total = 0; m_phase = 0; m_lap_total = 0;
    m_lap_valid = 0; m_ovf = 0; m_done = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit tick;
    tick  = run && (m_phase == DIV - 1);
    m_ovf = 0;
    m_done = 0;
    if (lap) begin
      m_lap_total = m_total;
      m_lap_valid = 1;
    end
    if (clear) begin
      m_total = 0;
      m_phase = 0;
    end else begin
      if (run) m_phase = (m_phase + 1) % DIV;
      if (load) begin
        m_total = clamp_total(load_value);
      end else if (tick) begin
        if (!mode) begin
          m_total = (m_total + 1) % DAY;
          m_ovf   = (m_total == 0);
        end else if (m_total != 0) begin
          m_total = m_total - 1;
          m_done  = (m_total == 0);
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    run = 0; clear = 0; load = 0; lap = 0;
  endtask

  task automatic test_reset();
    idle();
    mode = 0; load_value = '0; reset_n = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (epoch !== 28'd0) begin failures++; $display("FAIL reset_epoch got=%h exp=0", epoch); end
    checks++; if (lap_epoch !== 28'd0) begin failures++; $display("FAIL reset_lap_epoch got=%h exp=0", lap_epoch); end
    checks++; if (lap_valid !== 1'b0) begin failures++; $display("FAIL reset_lap_valid got=%b exp=0", lap_valid); end
    checks++; if ({overflow, done} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {overflow, done}); end
    reset_n = 1;
    step();
  endtask

  task automatic test_up_count();
    int bad;
    bad = 0;
    clear = 1; mode = 0; step(); clear = 0;
    run = 1;
    for (int i = 0; i < 1000; i++) begin
      step();
      if ({epoch, overflow, done} !== {to_epoch(m_total), m_ovf, m_done}) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL up_count_trace got=%0d bad cycles exp=0", bad); end
    checks++; if (epoch !== mk(0, 0, 1, 0)) begin failures++; $display("FAIL up_count_1s got=%h exp=%h", epoch, mk(0, 0, 1, 0)); end
    run = 0;
    repeat (37) step();
    checks++; if (epoch !== mk(0, 0, 1, 0)) begin failures++; $display("FAIL up_count_hold got=%h exp=%h", epoch, mk(0, 0, 1, 0)); end
  endtask

  task automatic test_wrap();
    int n_ovf;
    n_ovf = 0;
    clear = 1; step(); clear = 0;
    load = 1; load_value = mk(23, 59, 59, 99); mode = 0; step(); load = 0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL wrap_load_no_ovf got=%b exp=0", overflow); end
    run = 1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (overflow) n_ovf++;
      if (i == 10) begin
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL wrap_ovf_cycle got=%b exp=1", overflow); end
      end
    end
    checks++; if (epoch !== 28'd0) begin failures++; $display("FAIL wrap_epoch got=%h exp=0", epoch); end
    run = 0; step();
    checks++; if (n_ovf != 1 || overflow !== 1'b0) begin failures++; $display("FAIL wrap_ovf_count got=%0d/%b exp=1/0", n_ovf, overflow); end
  endtask

  task automatic test_countdown();
    int n_done, bad;
    n_done = 0; bad = 0;
    clear = 1; step(); clear = 0;
    load = 1; load_value = mk(0, 0, 0, 2); mode = 1; step(); load = 0;
    run = 1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done) n_done++;
      if (i == 20) begin
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL countdown_done_cycle got=%b exp=1", done); end
      end
    end
    checks++; if (epoch !== 28'd0 || n_done != 1) begin failures++; $display("FAIL countdown_zero got=%h/%0d exp=0/1", epoch, n_done); end
    for (int i = 0; i < 50; i++) begin
      step();
      if (epoch !== 28'd0 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL countdown_hold got=%0d bad cycles exp=0", bad); end
    run = 0; mode = 0;
  endtask

  task automatic test_priority();
    int lat;
    clear = 1; step(); clear = 0;
    run = 1;
    for (int i = 0; i < 3 * DIV && m_phase != DIV - 1; i++) step();
    for (int i = 0; i < 2 * DIV && m_phase != DIV - 1; i++) step();
    clear = 1; load = 1; load_value = mk(5, 6, 7, 8); step();
    clear = 0; load = 0;
    checks++; if (epoch !== 28'd0 || overflow !== 1'b0) begin failures++; $display("FAIL prio_clear_wins got=%h exp=0", epoch); end
    lat = 0;
    while (epoch == 28'd0 && lat < 4 * DIV) begin step(); lat++; end
    checks++; if (lat != DIV) begin failures++; $display("FAIL prio_div_reset got=%0d cycles exp=%0d", lat, DIV); end
    run = 0;
    load = 1; load_value = mk(30, 70, 70, 120); step(); load = 0;
    checks++; if (epoch !== mk(23, 59, 59, 99)) begin failures++; $display("FAIL prio_clamp got=%h exp=%h", epoch, mk(23, 59, 59, 99)); end
  endtask

  task automatic test_lap();
    clear = 1; mode = 0; step(); clear = 0;
    run = 1;
    for (int i = 0; i < 200 && !(m_total == 4 && m_phase == DIV - 1); i++) step();
    lap = 1; step(); lap = 0;
    checks++; if (lap_epoch !== (LAP_EN ? mk(0, 0, 0, 4) : 28'd0)) begin failures++; $display("FAIL lap_capture got=%h exp=%h", lap_epoch, LAP_EN ? mk(0, 0, 0, 4) : 28'd0); end
    checks++; if (lap_valid !== LAP_EN || epoch !== mk(0, 0, 0, 5)) begin failures++; $display("FAIL lap_valid_epoch got=%b/%h exp=%b/%h", lap_valid, epoch, LAP_EN, mk(0, 0, 0, 5)); end
    clear = 1; step(); clear = 0;
    checks++; if (lap_valid !== LAP_EN || epoch !== 28'd0) begin failures++; $display("FAIL lap_after_clear got=%b/%h exp=%b/0", lap_valid, epoch, LAP_EN); end
    run = 0;
  endtask

  task automatic test_reset_async();
    int lat;
    clear = 1; step(); clear = 0;
    run = 1; lap = 1; step(); lap = 0;
    repeat (23) step();
    #3;
    reset_n = 0;
    model_reset();
    #1;
    checks++; if ({epoch, lap_epoch, lap_valid, overflow, done} !== 59'd0) begin failures++; $display("FAIL async_reset got=%h/%h/%b%b%b exp=0", epoch, lap_epoch, lap_valid, overflow, done); end
    run = 0;
    @(posedge clock); #1;
    reset_n = 1;
    step();
    run = 1;
    lat = 0;
    while (epoch == 28'd0 && lat < 4 * DIV) begin step(); lat++; end
    checks++; if (lat != DIV) begin failures++; $display("FAIL reset_first_tick got=%0d cycles exp=%0d", lat, DIV); end
    run = 0;
  endtask

  task automatic test_random();
    logic [27:0] edge_vals [4];
    edge_vals[0] = mk(23, 59, 59, 97);
    edge_vals[1] = mk(0, 0, 0, 3);
    edge_vals[2] = mk(0, 1, 0, 0);
    edge_vals[3] = mk(12, 0, 59, 99);
    for (int i = 0; i < 1500; i++) begin
      run   = ($urandom % 8) != 0;
      clear = ($urandom % 200) == 0;
      load  = ($urandom % 60) == 0;
      lap   = ($urandom % 17) == 0;
      if (($urandom % 120) == 0) mode = ~mode;
      load_value = ($urandom % 2) ? edge_vals[$urandom % 4] : 28'($urandom);
      step();
      checks++;
      if ({epoch, lap_epoch, lap_valid, overflow, done} !==
          {to_epoch(m_total), exp_lap_epoch(), exp_lap_valid(), m_ovf, m_done}) begin
        failures++;
        $display("FAIL random_cycle_%0d got=%h/%h/%b%b%b exp=%h/%h/%b%b%b", i,
                 epoch, lap_epoch, lap_valid, overflow, done,
                 to_epoch(m_total), exp_lap_epoch(), exp_lap_valid(), m_ovf, m_done);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_wrap();
    test_countdown();
    test_priority();
    test_lap();
    test_reset_async();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stopwatch_timer.md
# stopwatch_timer

Parametrised successor to the board stopwatch: an up/down hours-minutes-seconds-centiseconds counter with load, countdown expiry, overflow indication and optional lap capture. It runs entirely in the system clock domain. A divided single-cycle tick enable replaces the gated clock, so the block drops straight into the display/top-level datapath next to the 7-segment decoders.

## Interface
Parameters:
- CLOCK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 100, count rate; the centisecond field counts 0..TICK_HZ-1. Must be ≤ 100.
- HOURS_MOD, 24, hours field counts 0..HOURS_MOD-1. Must be ≤ 100.

Ports:
- clock  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  level; count while high, hold while low.
- clear  in  1  synchronous pulse; zero the count and the divider.
- mode  in  1  0 = count up, 1 = count down.
- load  in  1  synchronous pulse; load load_value.
- load_value  in  28  packed epoch to load.
- lap  in  1  pulse; capture the current epoch.
- epoch  out  28  [6:0] centisec, [13:7] sec, [20:14] min, [27:21] hours.
- lap_epoch  out  28  last captured epoch.
- lap_valid  out  1  high once any lap has been captured.
- overflow  out  1  one-cycle pulse on up-count wrap from max to 0.
- done  out  1  one-cycle pulse when a down-count reaches 0.

## Operation
- Divider: DIV = CLOCK_HZ/TICK_HZ; integer part only. div_cnt counts 0..DIV-1 while run=1 and holds while run=0. The tick is high for the one cycle in which div_cnt == DIV-1 and run=1; div_cnt then returns to 0.
- Up count on tick: cs+1. At TICK_HZ-1, cs → 0 and sec carries. sec and min wrap at 59 with carry. Hours wrap at HOURS_MOD-1.
  - From max (HOURS_MOD-1:59:59:TICK_HZ-1), the next tick gives all zero and pulses overflow.
- Down count on tick: decrement with borrow; cs borrows to TICK_HZ-1, sec and min borrow to 59, hours borrow to HOURS_MOD-1.
  - The tick that makes the epoch 0 pulses done.
  - At 0, further ticks hold 0. There is no wrap and no repeated done.
- Priority per cycle: clear > load > tick.
  - clear zeros epoch and div_cnt.
  - load writes load_value with each field clamped to its max and does not touch div_cnt.
  - Neither clear nor load pulses overflow or done.
- Changing mode takes effect on the next tick. The count is unchanged.
- Lap: when lap=1, lap_epoch ← epoch as it stands at the start of that cycle, i.e. before any same-cycle tick, clear or load. lap_valid is set and stays set until reset; clear does not affect it.
- Reset: asynchronous. epoch, lap_epoch, div_cnt = 0; lap_valid, overflow, done = 0.

## Timing
- All outputs are registered.
- The epoch changes on the clock edge at which the tick is high. Latency from the first run=1 cycle after clear to the first epoch change is DIV cycles.
- overflow and done assert in the same cycle the epoch shows the wrapped or zero value, for exactly 1 cycle.
- lap_epoch and lap_valid update 1 cycle after lap.
- Deasserting run mid-period freezes div_cnt. Reasserting run resumes from that value, so no time is lost or gained.
- If reset_n is asserted mid-period, the divider phase is lost.

## Configuration
- STOPWATCH_LAP_EN defined: the lap register and logic are present as described.
- STOPWATCH_LAP_EN undefined: the lap input is ignored, lap_epoch ties to 0 and lap_valid ties to 0. Port list is unchanged.

## Structure
- Package stopwatch_pkg holds:
  - FIELD_W = 7 and EPOCH_W = 28;
  - field index constants CS, SEC, MIN, HR;
  - SEC_MAX = 59 and MIN_MAX = 59;
  - the packed epoch typedef (four 7-bit fields).
- Sub-module tick_divider (parameters CLOCK_HZ, TICK_HZ; ports clock, reset_n, run, clear, tick). The top instantiates it and holds the counter, load, lap and flag logic.

## Test plan
All scenarios use CLOCK_HZ=1000, TICK_HZ=100, so DIV=10.
1. Up count: clear, then run=1 for 1000 cycles → epoch = 0:00:01:00 (sec=1, cs=0). Drop run for 37 cycles → epoch is unchanged.
2. Wrap: load 23:59:59:99 with mode=0, then 10 cycles of run → epoch = 0; overflow high for exactly 1 cycle.
3. Countdown: load 0:00:00:02 with mode=1, then run 20 cycles → epoch = 0; done pulses once on the 20th cycle. A further 50 cycles → epoch stays 0 and done stays 0.
4. Priority: clear, load and tick in the same cycle → epoch = 0 and div_cnt = 0. load_value 30:70:70:120 → loaded epoch = 23:59:59:99.
5. Lap: lap asserted in the cycle a tick moves cs 4→5 → lap_epoch cs = 4 and lap_valid = 1 one cycle later. A following clear leaves lap_valid = 1. With STOPWATCH_LAP_EN undefined → lap_epoch = 0 and lap_valid = 0.
6. Reset: assert reset_n low mid-count, asynchronously off the clock edge → all outputs are 0 immediately. After release, the first tick comes 10 cycles after the first run=1 cycle.
